// File: rtl/branch_stall_if.sv
// Fetch-side view of the branch stall unit: instruction in, branch status out.
// The fetch stage drives the master side; the stall unit sits on the slave side.
interface branch_stall_if #(
    parameter int CNT_WIDTH = 16
);
    logic [31:0]          Inst;
    logic                 Inst_valid;
    logic                 Br_Resolved;
    logic                 Br_Detected;
    logic [1:0]           Br_Type;
    logic                 Stall;
    logic                 Busy;
    logic [CNT_WIDTH-1:0] Br_Count;

    modport master (
        output Inst,
        output Inst_valid,
        output Br_Resolved,
        input  Br_Detected,
        input  Br_Type,
        input  Stall,
        input  Busy,
        input  Br_Count
    );

    modport slave (
        input  Inst,
        input  Inst_valid,
        input  Br_Resolved,
        output Br_Detected,
        output Br_Type,
        output Stall,
        output Busy,
        output Br_Count
    );
endinterface

// File: rtl/branch_stall_unit.sv
// Detects RV32I branches/jumps at fetch and freezes fetch/decode, either for a
// fixed number of cycles or until the branch outcome is reported resolved.
module branch_stall_unit #(
    parameter int STALL_CYCLES = 3,
    parameter int RESOLVE_MODE = 0,
    parameter int CNT_WIDTH    = 16
) (
    input  logic           clk,
    input  logic           rst,
    branch_stall_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STALL = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] LP_STALL_LEN = 4'(STALL_CYCLES);
    localparam logic [1:0] LP_BT_NONE   = 2'b00;
    localparam logic [1:0] LP_BT_COND   = 2'b01;
    localparam logic [1:0] LP_BT_JAL    = 2'b10;
    localparam logic [1:0] LP_BT_JALR   = 2'b11;

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_stall_cnt;
    logic [3:0]           w_stall_cnt_next;
    logic                 r_br_detected;
    logic                 w_br_detected_next;
    logic [1:0]           r_br_type;
    logic [1:0]           w_br_type_next;
    logic                 r_stall;
    logic                 w_stall_next;
    logic [CNT_WIDTH-1:0] r_br_count;
    logic [CNT_WIDTH-1:0] w_br_count_next;

    logic [6:0]           w_opcode;
    logic [2:0]           w_funct3;
    logic [1:0]           w_class;
    logic                 w_accept;
    logic                 w_unused_inst_bits;

    assign w_opcode = bus.Inst[6:0];
    assign w_funct3 = bus.Inst[14:12];
    assign w_unused_inst_bits = ^{bus.Inst[31:15], bus.Inst[11:7]};

    // funct3 010/011 under the branch opcode are unallocated, so not branches
    always_comb begin
        w_class = LP_BT_NONE;
        case (w_opcode)
            7'b1100011: begin
                if ((w_funct3 != 3'b010) && (w_funct3 != 3'b011)) begin
                    w_class = LP_BT_COND;
                end
            end
            7'b1101111: w_class = LP_BT_JAL;
            7'b1100111: begin
                if (w_funct3 == 3'b000) begin
                    w_class = LP_BT_JALR;
                end
            end
            default: w_class = LP_BT_NONE;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && bus.Inst_valid && (w_class != LP_BT_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (RESOLVE_MODE != 0) ? S_WAIT : S_STALL;
                end
            end
            S_STALL: begin
                if (r_stall_cnt <= 4'd1) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (bus.Br_Resolved) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; everything leaves on a clock edge
    always_comb begin
        w_stall_cnt_next   = r_stall_cnt;
        w_br_detected_next = w_accept;
        w_br_type_next     = r_br_type;
        w_stall_next       = (w_state_next != S_IDLE);
        w_br_count_next    = r_br_count;

        if (w_accept) begin
            w_br_type_next   = w_class;
            w_stall_cnt_next = (RESOLVE_MODE != 0) ? 4'd0 : LP_STALL_LEN;
            if (r_br_count != {CNT_WIDTH{1'b1}}) begin
                w_br_count_next = r_br_count + 1'b1;
            end
        end else if (w_state_next == S_IDLE) begin
            w_br_type_next   = LP_BT_NONE;
            w_stall_cnt_next = 4'd0;
        end else if ((r_state == S_STALL) && (r_stall_cnt != 4'd0)) begin
            w_stall_cnt_next = r_stall_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt   <= 4'd0;
            r_br_detected <= 1'b0;
            r_br_type     <= LP_BT_NONE;
            r_stall       <= 1'b0;
            r_br_count    <= '0;
        end else begin
            r_stall_cnt   <= w_stall_cnt_next;
            r_br_detected <= w_br_detected_next;
            r_br_type     <= w_br_type_next;
            r_stall       <= w_stall_next;
            r_br_count    <= w_br_count_next;
        end
    end

    assign bus.Br_Detected = r_br_detected;
    assign bus.Br_Type     = r_br_type;
    assign bus.Stall       = r_stall;
    assign bus.Busy        = r_stall;
    assign bus.Br_Count    = r_br_count;

endmodule
